// File: rtl/note_player_pkg.sv
// Shared definitions for the note sequencing front end: default widths,
// musical constants and the player state encoding.
package note_player_pkg;

  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_DUR_WIDTH    = 6;
  localparam int DEF_NOTE_WIDTH   = 6;

  localparam int REST_NOTE        = 0;
  localparam int BEATS_PER_SECOND = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    REST  = 2'd3
  } state_t;

endpackage

// File: rtl/note_player_if.sv
// Sample path between the note player, the upstream wave generator and the
// downstream dynamics block. The note player is the master side.
interface note_player_if
  import note_player_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int NOTE_WIDTH   = DEF_NOTE_WIDTH,
  parameter int DUR_WIDTH    = DEF_DUR_WIDTH
);
  logic                           src_req;
  logic [NOTE_WIDTH-1:0]          src_note;
  logic signed [SAMPLE_WIDTH-1:0] src_sample;
  logic                           src_valid;
  logic [DUR_WIDTH-1:0]           note_duration;
  logic signed [SAMPLE_WIDTH-1:0] sample_start;
  logic                           new_sample_ready;

  modport master (
    output src_req, src_note, note_duration, sample_start, new_sample_ready,
    input  src_sample, src_valid
  );

  modport slave (
    input  src_req, src_note, note_duration, sample_start, new_sample_ready,
    output src_sample, src_valid
  );
endinterface

// File: rtl/note_player_duration_counter.sv
// Loadable beat down-counter with a registered pulse when it reaches zero,
// either by counting down or by being loaded with zero.
module duration_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             last_beat,
  output logic             zero_pulse
);
  logic [WIDTH-1:0] count;

  // Combinational look-ahead so the owner can leave its active state on the
  // same edge that the registered zero pulse is raised.
  assign last_beat = enable && !load && (count == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      zero_pulse <= 1'b0;
    end else if (load) begin
      count      <= load_value;
      zero_pulse <= (load_value == '0);
    end else if (enable && (count != '0)) begin
      count      <= count - 1'b1;
      zero_pulse <= (count == WIDTH'(1));
    end else begin
      zero_pulse <= 1'b0;
    end
  end
endmodule

// File: rtl/note_player.sv
// Latches a note and its duration, fetches samples from the wave generator on
// codec request, presents them to dynamics and signals note expiry in beats.
module note_player
  import note_player_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int DUR_WIDTH    = DEF_DUR_WIDTH,
  parameter int NOTE_WIDTH   = DEF_NOTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  load_new_note,
  input  logic [NOTE_WIDTH-1:0] note_to_load,
  input  logic [DUR_WIDTH-1:0]  duration_to_load,
  input  logic                  beat,
  input  logic                  generate_next_sample,
  note_player_if.master         bus,
  output logic                  done_with_note,
  output logic                  busy
);
  state_t state;
  logic   req_pending;
  logic   last_beat;
  logic   count_enable;

  assign count_enable = beat && play_enable && (state != IDLE);

  duration_counter #(
    .WIDTH (DUR_WIDTH)
  ) u_duration_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (load_new_note),
    .load_value (duration_to_load),
    .enable     (count_enable),
    .last_beat  (last_beat),
    .zero_pulse (done_with_note)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      busy                 <= 1'b0;
      req_pending          <= 1'b0;
      bus.src_req          <= 1'b0;
      bus.src_note         <= '0;
      bus.note_duration    <= '0;
      bus.sample_start     <= '0;
      bus.new_sample_ready <= 1'b0;
    end else begin
      bus.src_req          <= 1'b0;
      bus.new_sample_ready <= 1'b0;
      if (load_new_note) begin
        bus.src_note      <= note_to_load;
        bus.note_duration <= duration_to_load;
        bus.sample_start  <= '0;
        req_pending       <= 1'b0;
        if (duration_to_load == '0) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (note_to_load == NOTE_WIDTH'(REST_NOTE)) begin
          state <= REST;
          busy  <= 1'b1;
        end else begin
          state <= FETCH;
          busy  <= 1'b1;
          // A request that cannot go out now (paused, or one just issued for
          // a back-to-back load) is deferred so strobes never run together.
          if (play_enable && !bus.src_req) begin
            bus.src_req <= 1'b1;
          end else begin
            req_pending <= 1'b1;
          end
        end
      end else if (last_beat) begin
        state            <= IDLE;
        busy             <= 1'b0;
        bus.sample_start <= '0;
      end else if (play_enable) begin
        case (state)
          FETCH: begin
            if (req_pending) begin
              bus.src_req <= 1'b1;
              req_pending <= 1'b0;
            end
            if (bus.src_valid) begin
              bus.sample_start     <= bus.src_sample;
              bus.new_sample_ready <= 1'b1;
              state                <= WAIT;
            end
          end
          WAIT: begin
            if (generate_next_sample) begin
              bus.src_req <= 1'b1;
              state       <= FETCH;
            end
          end
          REST: begin
            if (generate_next_sample) begin
              bus.new_sample_ready <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
